// File: rtl/fir_tdm_filter.sv
// Time-multiplexed multi-channel FIR: one shared signed MAC walks all taps.
// Macro FIR_ROUND_SAT_EN adds a round/saturate output stage (+1 cycle).
//
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   WR/iCH/iDATA      sample write strobe, channel, signed sample
//   iREADY            high when a sample can be accepted
//   COEF_WR/ADDR/DATA coefficient write port (ignored while busy)
//   oVALID/oCH/oDATA  one-cycle result strobe, channel, signed result
module fir_tdm_filter #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int N_TAPS = 128,
    parameter int N_CH   = 2,
`ifdef FIR_ROUND_SAT_EN
    parameter int FRAC_BITS = 15,
`endif
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int AW    = $clog2(N_TAPS),
    localparam int OUT_W = DATA_W + COEF_W + $clog2(N_TAPS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              WR,
    input  logic [CH_W-1:0]   iCH,
    input  logic [DATA_W-1:0] iDATA,
    output logic              iREADY,
    input  logic              COEF_WR,
    input  logic [AW-1:0]     COEF_ADDR,
    input  logic [COEF_W-1:0] COEF_DATA,
    output logic              oVALID,
    output logic [CH_W-1:0]   oCH,
    output logic [OUT_W-1:0]  oDATA
);

    localparam int PW = DATA_W + COEF_W;
    localparam int KW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [KW-1:0]             k_q, k_d;
    logic [CH_W-1:0]           ch_q, ch_d;
    logic signed [OUT_W-1:0]   acc_q, acc_d;
    logic signed [PW-1:0]      prod_q, prod_d;
    logic                      prod_v_q, prod_v_d;
    logic                      ovalid_q, ovalid_d;
    logic [CH_W-1:0]           och_q, och_d;
    logic signed [OUT_W-1:0]   odata_q, odata_d;
    logic [AW-1:0]             wp_q [N_CH];
    logic [AW-1:0]             wp_d [N_CH];
    logic signed [DATA_W-1:0]  dl_q [N_CH][N_TAPS];
    logic signed [COEF_W-1:0]  coef_q [N_TAPS];

    logic                      accept;
    logic                      dl_we;
    logic [AW-1:0]             dl_idx;
    logic                      cf_we;
    logic [AW-1:0]             kk;
    logic [AW-1:0]             wp_cur;
    logic [KW-1:0]             wrap_idx;
    logic [AW-1:0]             rd_idx;

`ifdef FIR_ROUND_SAT_EN
    localparam logic signed [OUT_W:0] RND_ONE = (OUT_W+1)'(1) << (FRAC_BITS-1);
    localparam logic signed [OUT_W:0] SAT_HI  = (OUT_W+1)'((1 << (DATA_W-1)) - 1);
    localparam logic signed [OUT_W:0] SAT_LO  = ~SAT_HI;

    logic signed [OUT_W:0]     rnd, shf, sat;
    logic signed [OUT_W-1:0]   res_q, res_d;
    logic                      res_v_q, res_v_d;
    logic [CH_W-1:0]           res_ch_q, res_ch_d;
`endif

    assign iREADY = (state_q != S_MAC);
    assign oVALID = ovalid_q;
    assign oCH    = och_q;
    assign oDATA  = odata_q;

    always_comb begin
        accept = WR && iREADY && (32'(iCH) < 32'(N_CH));
        cf_we  = COEF_WR && iREADY && (32'(COEF_ADDR) < 32'(N_TAPS));

        // Delay-line read index (wp - k) mod N_TAPS, valid for any N_TAPS.
        kk       = k_q[AW-1:0];
        wp_cur   = wp_q[ch_q];
        wrap_idx = {1'b0, wp_cur} + KW'(N_TAPS) - {1'b0, kk};
        rd_idx   = (wp_cur >= kk) ? (wp_cur - kk) : wrap_idx[AW-1:0];

        state_d  = state_q;
        k_d      = k_q;
        ch_d     = ch_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        prod_v_d = 1'b0;
        ovalid_d = 1'b0;
        och_d    = och_q;
        odata_d  = odata_q;
        dl_we    = 1'b0;
        dl_idx   = '0;
        for (int c = 0; c < N_CH; c++) wp_d[c] = wp_q[c];

`ifdef FIR_ROUND_SAT_EN
        rnd      = {acc_q[OUT_W-1], acc_q} + RND_ONE;
        shf      = rnd >>> FRAC_BITS;
        sat      = (shf > SAT_HI) ? SAT_HI : ((shf < SAT_LO) ? SAT_LO : shf);
        res_d    = res_q;
        res_v_d  = 1'b0;
        res_ch_d = res_ch_q;
        ovalid_d = res_v_q;
        if (res_v_q) begin
            odata_d = res_q;
            och_d   = res_ch_q;
        end
`endif

        unique case (state_q)
            S_IDLE: ;
            S_MAC: begin
                // Product stage runs one cycle ahead of the accumulator.
                if (prod_v_q) acc_d = acc_q + {{(OUT_W-PW){prod_q[PW-1]}}, prod_q};
                if (k_q < KW'(N_TAPS)) begin
                    prod_d   = dl_q[ch_q][rd_idx] * coef_q[kk];
                    prod_v_d = 1'b1;
                    k_d      = k_q + KW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
`ifdef FIR_ROUND_SAT_EN
                res_d    = sat[OUT_W-1:0];
                res_v_d  = 1'b1;
                res_ch_d = ch_q;
`else
                ovalid_d = 1'b1;
                odata_d  = acc_q;
                och_d    = ch_q;
`endif
                wp_d[ch_q] = (wp_q[ch_q] == AW'(N_TAPS-1)) ? '0 : wp_q[ch_q] + AW'(1);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Accept after the pointer advance so a same-channel sample taken
        // in DONE lands in the next slot.
        if (accept) begin
            state_d  = S_MAC;
            k_d      = '0;
            ch_d     = iCH;
            acc_d    = '0;
            prod_v_d = 1'b0;
            dl_we    = 1'b1;
            dl_idx   = wp_d[iCH];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            ch_q     <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            ovalid_q <= 1'b0;
            och_q    <= '0;
            odata_q  <= '0;
            for (int c = 0; c < N_CH; c++) begin
                wp_q[c] <= '0;
                for (int t = 0; t < N_TAPS; t++) dl_q[c][t] <= '0;
            end
            for (int t = 0; t < N_TAPS; t++) coef_q[t] <= '0;
`ifdef FIR_ROUND_SAT_EN
            res_q    <= '0;
            res_v_q  <= 1'b0;
            res_ch_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            ch_q     <= ch_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            ovalid_q <= ovalid_d;
            och_q    <= och_d;
            odata_q  <= odata_d;
            for (int c = 0; c < N_CH; c++) wp_q[c] <= wp_d[c];
            if (dl_we) dl_q[iCH][dl_idx] <= iDATA;
            if (cf_we) coef_q[COEF_ADDR] <= COEF_DATA;
`ifdef FIR_ROUND_SAT_EN
            res_q    <= res_d;
            res_v_q  <= res_v_d;
            res_ch_q <= res_ch_d;
`endif
        end
    end

endmodule

// File: tb/tb_fir_tdm_filter.sv
// Self-checking bench for fir_tdm_filter (default parameters).
// Reference model: per-channel sample history and a coefficient table.
module tb_fir_tdm_filter;

    localparam int NT = 128;
`ifdef FIR_ROUND_SAT_EN
    localparam int LAT = NT + 3;
`else
    localparam int LAT = NT + 2;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               wr = 1'b0;
    logic [0:0]         ich = '0;
    logic [15:0]        idata = '0;
    logic               iready;
    logic               coef_wr = 1'b0;
    logic [6:0]         coef_addr = '0;
    logic [15:0]        coef_data = '0;
    logic               ovalid;
    logic [0:0]         och;
    logic signed [38:0] odata;

    int total = 0;
    int bad   = 0;

    longint cm [NT];
    longint hm [2][NT];

    fir_tdm_filter dut (
        .CLK       (clk),
        .RESET     (rst),
        .WR        (wr),
        .iCH       (ich),
        .iDATA     (idata),
        .iREADY    (iready),
        .COEF_WR   (coef_wr),
        .COEF_ADDR (coef_addr),
        .COEF_DATA (coef_data),
        .oVALID    (ovalid),
        .oCH       (och),
        .oDATA     (odata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NT; k++) begin
            cm[k] = 0;
            hm[0][k] = 0;
            hm[1][k] = 0;
        end
    endtask

    task automatic model_push(input int c, input logic signed [15:0] x);
        for (int k = NT - 1; k > 0; k--) hm[c][k] = hm[c][k-1];
        hm[c][0] = longint'(x);
    endtask

    function automatic longint model_out(input int c);
        longint s = 0;
        for (int k = 0; k < NT; k++) s += cm[k] * hm[c][k];
`ifdef FIR_ROUND_SAT_EN
        s = (s + (64'sd1 <<< 14)) >>> 15;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`endif
        return s;
    endfunction

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic setcoef(input int a, input logic signed [15:0] d);
        coef_wr = 1'b1;
        coef_addr = 7'(a);
        coef_data = d;
        tick();
        coef_wr = 1'b0;
        cm[a] = longint'(d);
    endtask

    task automatic send(input int c, input logic signed [15:0] x,
                        input string tag, output longint res,
                        input bit cw = 1'b0, input int ca = 0,
                        input int cd = 0);
        int w;
        int lat;
        longint e;
        w = 0;
        while (!iready && w < 300) begin
            tick();
            w++;
        end
        chk({tag, "_rdy"}, 64'(iready), 1);
        wr = 1'b1;
        ich = 1'(c);
        idata = x;
        if (cw) begin
            coef_wr = 1'b1;
            coef_addr = 7'(ca);
            coef_data = 16'(cd);
        end
        tick();
        wr = 1'b0;
        coef_wr = 1'b0;
        if (cw) cm[ca] = longint'($signed(16'(cd)));
        model_push(c, x);
        e = model_out(c);
        lat = 0;
        while (!ovalid && lat < 400) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_ch"}, 64'(och), c);
        chk({tag, "_data"}, odata, e);
        res = odata;
        tick();
        chk({tag, "_pulse"}, 64'(ovalid), 0);
        chk({tag, "_hold"}, odata, e);
    endtask

    initial begin
        longint r;
        longint dv;
        int low;
        int nv;
        int lv;

        model_clear();
        // Reset state
        do_reset(2);
        chk("rst_valid", 64'(ovalid), 0);
        chk("rst_ready", 64'(iready), 1);
        chk("rst_data", odata, 0);
        chk("rst_ch", 64'(och), 0);
        send(0, 16'h1234, "zero_coef", r);
        chk("zero_coef_lit", r, 0);

        // Impulse
        do_reset(1);
        for (int k = 0; k < 4; k++) setcoef(k, 16'(k + 1));
        send(0, 16'sd1, "imp0", r);
        for (int i = 1; i < 5; i++) send(0, 16'sd0, "imp", r);

        // Channel isolation
        send(1, 16'sd100, "iso_c1a", r);
        send(0, 16'sd1, "iso_c0a", r);
        send(0, 16'sd0, "iso_c0b", r);
        send(1, 16'sd0, "iso_c1b", r);

        // Busy drop, with coefficient writes attempted mid-MAC
        wr = 1'b1;
        ich = 1'b0;
        idata = 16'sd11;
        tick();
        wr = 1'b0;
        model_push(0, 16'sd11);
        low = 0;
        nv = 0;
        lv = -1;
        dv = 0;
        for (int i = 1; i <= LAT + 20; i++) begin
            if (!iready) begin
                low++;
                wr = 1'b1;
                ich = 1'($urandom_range(0, 1));
                idata = 16'($urandom);
                coef_wr = 1'b1;
                coef_addr = 7'($urandom_range(0, 3));
                coef_data = 16'($urandom);
            end else begin
                wr = 1'b0;
                coef_wr = 1'b0;
            end
            tick();
            if (ovalid) begin
                nv++;
                if (lv < 0) begin
                    lv = i;
                    dv = odata;
                end
            end
        end
        wr = 1'b0;
        coef_wr = 1'b0;
        chk("busy_low", low, NT + 1);
        chk("busy_nvalid", nv, 1);
        chk("busy_lat", lv, LAT);
        chk("busy_data", dv, model_out(0));

        // Random coefficients and samples, some with same-edge coef write
        do_reset(1);
        for (int k = 0; k < NT; k++) setcoef(k, 16'($urandom));
        for (int i = 0; i < 24; i++) begin
            if (i % 5 == 2)
                send($urandom_range(0, 1), 16'($urandom), "rnd_cw", r,
                     1'b1, $urandom_range(0, NT - 1), $urandom_range(0, 65535));
            else
                send($urandom_range(0, 1), 16'($urandom), "rnd", r);
        end

        // Reset in the middle of a MAC
        do_reset(1);
        for (int k = 0; k < 4; k++) setcoef(k, 16'(k + 1));
        wr = 1'b1;
        ich = 1'b0;
        idata = 16'sd77;
        tick();
        wr = 1'b0;
        repeat (50) tick();
        do_reset(1);
        chk("mid_ready", 64'(iready), 1);
        chk("mid_valid", 64'(ovalid), 0);
        chk("mid_data", odata, 0);
        nv = 0;
        for (int i = 0; i < LAT + 20; i++) begin
            tick();
            if (ovalid) nv++;
        end
        chk("mid_novalid", nv, 0);
        for (int k = 0; k < 4; k++) setcoef(k, 16'(k + 1));
        send(0, 16'sd1, "mid_imp0", r);
        chk("mid_imp0_lit", r, model_out(0));
        for (int i = 1; i < 5; i++) send(0, 16'sd0, "mid_imp", r);

        // Extreme magnitude
        do_reset(1);
        for (int k = 0; k < NT; k++) setcoef(k, 16'h8000);
        for (int i = 0; i < NT; i++) send(0, 16'h8000, "ext", r);
`ifdef FIR_ROUND_SAT_EN
        chk("ext_final", r, 32767);
`else
        chk("ext_final", r, 64'sd1 <<< 37);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_tdm_filter.md
Name: fir_tdm_filter

Overview:
Parametrised, multi-channel, time-multiplexed FIR filter core. It is the successor to the fixed 16-bit-in / 39-bit-out FIR core that sits behind the chip pad ring.
- One shared signed MAC walks all taps serially.
- Each channel has its own circular delay line.
- Coefficients are runtime-programmable.
- Accepted samples are handshaked with a ready signal; results are marked with a valid pulse.

Parameters:
DATA_W, 16, signed sample width
COEF_W, 16, signed coefficient width
N_TAPS, 128, taps per channel (>=2)
N_CH, 2, independent channels (>=1)
CH_W (local), max(1,$clog2(N_CH)), channel index width
OUT_W (local), DATA_W+COEF_W+$clog2(N_TAPS), output width (default 39)

Ports:
CLK  in  1  clock
RESET  in  1  reset
WR  in  1  sample write strobe
iCH  in  CH_W  channel of incoming sample
iDATA  in  DATA_W  signed sample
iREADY  out  1  high when a sample can be accepted
COEF_WR  in  1  coefficient write strobe
COEF_ADDR  in  $clog2(N_TAPS)  tap index
COEF_DATA  in  COEF_W  signed coefficient
oVALID  out  1  one-cycle result strobe
oCH  out  CH_W  channel of result
oDATA  out  OUT_W  signed filter output

Behaviour:
- Clocking and reset (already decided): single clock CLK, all state on rising edge. RESET is synchronous and active-high.
- Reset values:
  - Outputs: iREADY=1, oVALID=0, oCH=0, oDATA=0.
  - Internal state: all delay lines and coefficients=0, all write pointers=0, FSM=IDLE.
- Accept: a sample is accepted on an edge where WR=1, iREADY=1 and iCH<N_CH.
  - WR with iCH>=N_CH is dropped with no state change.
  - WR while iREADY=0 is dropped; it is not queued.
- FSM states:
  - IDLE (iREADY=1). On accept: write iDATA at the channel's write pointer, latch the channel, clear the accumulator, go to MAC.
  - MAC (iREADY=0). k runs 0..N_TAPS-1, one tap per cycle: acc += coef[k]*x[n-k], where x[n] is the sample just written. Delay-line index = (wp-k) mod N_TAPS. Product has a 1-stage register. After the last product, go to DONE.
  - DONE: oDATA<=acc, oCH<=channel, oVALID=1 for one cycle, iREADY=1 in the same cycle. Advance that channel's write pointer (wrap N_TAPS-1 -> 0). Go to IDLE.
- Latency: oVALID is asserted exactly N_TAPS+2 cycles after the accepting edge. Back-to-back throughput is one sample per N_TAPS+2 cycles; a WR in the DONE cycle is accepted.
- Output hold: oDATA and oCH hold their value until the next DONE.
- Arithmetic: signed two's complement throughout. The accumulator is OUT_W bits and cannot overflow, including N_TAPS * (-2^(DATA_W-1)) * (-2^(COEF_W-1)).
- Coefficients:
  - COEF_WR is honoured only in IDLE and DONE; it is ignored in MAC.
  - COEF_ADDR>=N_TAPS is ignored.
  - If COEF_WR and an accepted WR occur on the same edge, the new coefficient is used by that sample's MAC.
- Channel isolation: a channel's delay line and pointer change only on an accept for that channel.
- Reset mid-MAC: the operation is aborted, no oVALID is produced, and all state returns to reset values.

Optional Feature:
FIR_ROUND_SAT_EN
- Defined: adds parameter FRAC_BITS (default 15). Result = acc + 2^(FRAC_BITS-1), arithmetic shift right by FRAC_BITS, saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then sign-extend into oDATA. Latency becomes N_TAPS+3 (one extra register stage).
- Undefined: oDATA carries the full-precision accumulator; latency is N_TAPS+2.

Test Plan:
- Reset: assert RESET 2 cycles -> oVALID=0, iREADY=1, oDATA=0, oCH=0; a WR with 0x1234 then yields oDATA=0 (all coefficients are zero).
- Impulse: coef[0..3]=1,2,3,4, rest 0; ch0 samples 1,0,0,0,0 -> oDATA 1,2,3,4,0, each oVALID exactly 130 cycles after its accept.
- Channel isolation: same coefficients; ch1 gets 100, then ch0 gets 1, 0 -> ch0 outputs 1, 2; the next ch1 sample 0 gives oCH=1, oDATA=200.
- Busy drop: WR pulsed every cycle during MAC -> only the first sample is accepted; iREADY low for 129 cycles; exactly one oVALID.
- Extreme magnitude: all coefficients 0x8000; 128 samples of 0x8000 on ch0 -> final oDATA = 2^37 with no wrap. With FIR_ROUND_SAT_EN defined, oDATA = 32767.
- Reset mid-operation: RESET 50 cycles after an accept -> no oVALID; iREADY=1 next cycle; the delay line reads back zero (impulse test passes afresh).
